// File: rtl/cpu_thread_switch_if.sv
// Bundles the CPU yield requests and the thread-context strobes of cpu_thread_switch.
// master = CPU pipeline / context-store side, slave = the thread switcher itself.
interface cpu_thread_switch_if #(
   parameter int N_THREADS = 16
);
   localparam int N_THREADS_MSB = $clog2(N_THREADS) - 1;

   logic [N_THREADS-1:0]   ready_set;
   logic                   switch_req;
   logic                   switch_block;
   logic [N_THREADS_MSB:0] thread_num;
   logic                   load_en;
   logic                   save_en;
   logic                   running;
   logic [N_THREADS-1:0]   ready;
   logic [15:0]            switch_count;

   modport master (
      output ready_set, switch_req, switch_block,
      input  thread_num, load_en, save_en, running, ready, switch_count
   );

   modport slave (
      input  ready_set, switch_req, switch_block,
      output thread_num, load_en, save_en, running, ready, switch_count
   );
endinterface

// File: rtl/cpu_thread_switch.sv
// Round-robin hardware thread switcher: saves the outgoing context, then loads the next ready one.
// Optional switch counter enabled by defining CPU_THREAD_SWITCH_STATS_EN.
module cpu_thread_switch #(
   parameter int N_THREADS     = 16,
   parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
   input logic                CLK,
   input logic                reset,
   cpu_thread_switch_if.slave bus
);
   localparam int TW = N_THREADS_MSB + 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, SAVE} state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        thread_num_q, thread_num_d;
   logic                 load_en_q, load_en_d;
   logic                 save_en_q, save_en_d;
   logic                 running_q, running_d;
   logic                 block_q, block_d;
   logic [N_THREADS-1:0] ready_q, ready_d;
   logic [N_THREADS-1:0] clear_mask;
   logic                 found;
   logic [TW-1:0]        next_thread;
   logic [TW-1:0]        cand;

   // A block-requested clear happens at the end of SAVE; a same-cycle ready_set still wins.
   always_comb begin
      clear_mask = '0;
      if (state_q == SAVE && block_q)
         clear_mask[thread_num_q] = 1'b1;
      ready_d = (ready_q & ~clear_mask) | bus.ready_set;
   end

   // Scan from thread_num+1 upward with wrap; offset N_THREADS lands back on the current thread.
   always_comb begin
      found       = 1'b0;
      next_thread = thread_num_q;
      cand        = '0;
      for (int i = 1; i <= N_THREADS; i++) begin
         cand = thread_num_q + TW'(i);
         if (!found && ready_d[cand]) begin
            found       = 1'b1;
            next_thread = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      thread_num_d = thread_num_q;
      load_en_d    = 1'b0;
      save_en_d    = 1'b0;
      running_d    = 1'b0;
      block_d      = block_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d      = LOAD;
               thread_num_d = next_thread;
               load_en_d    = 1'b1;
            end
         end
         LOAD: begin
            state_d   = RUN;
            running_d = 1'b1;
         end
         RUN: begin
            if (bus.switch_req) begin
               state_d   = SAVE;
               save_en_d = 1'b1;
               block_d   = bus.switch_block;
            end else begin
               running_d = 1'b1;
            end
         end
         SAVE: begin
            if (found) begin
               state_d      = LOAD;
               thread_num_d = next_thread;
               load_en_d    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q      <= IDLE;
         thread_num_q <= '0;
         load_en_q    <= 1'b0;
         save_en_q    <= 1'b0;
         running_q    <= 1'b0;
         block_q      <= 1'b0;
         ready_q      <= '0;
      end else begin
         state_q      <= state_d;
         thread_num_q <= thread_num_d;
         load_en_q    <= load_en_d;
         save_en_q    <= save_en_d;
         running_q    <= running_d;
         block_q      <= block_d;
         ready_q      <= ready_d;
      end
   end

   assign bus.thread_num = thread_num_q;
   assign bus.load_en    = load_en_q;
   assign bus.save_en    = save_en_q;
   assign bus.running    = running_q;
   assign bus.ready      = ready_q;

`ifdef CPU_THREAD_SWITCH_STATS_EN
   logic [15:0] switch_count_q, switch_count_d;

   // Every entry into LOAD is one switch; the counter sticks at all-ones.
   always_comb begin
      switch_count_d = switch_count_q;
      if (load_en_d && switch_count_q != 16'hFFFF)
         switch_count_d = switch_count_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (reset)
         switch_count_q <= '0;
      else
         switch_count_q <= switch_count_d;
   end

   assign bus.switch_count = switch_count_q;
`else
   assign bus.switch_count = 16'h0000;
`endif
endmodule
